// File: rtl/bus_resp_pkg.sv
// Shared types and widths for the bus responder: FSM state encoding and bus widths.
package bus_resp_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 19;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

endpackage

// File: rtl/bus_resp_regfile.sv
// Register storage for the bus responder: one write port, one combinational read port,
// asynchronously cleared to zero.
module bus_resp_regfile
    import bus_resp_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    // NUM_REGS is a power of two, so every index value selects a real register.
    assign rdata = regs_q[raddr];

endmodule

// File: rtl/bus_responder.sv
// Register-file bus slave with programmable response latency, error detection on
// misaligned or out-of-range addresses, and a saturating error counter.
module bus_responder
    import bus_resp_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              m_wr_en,
    output logic              s_ack,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_error,
    output logic [7:0]        err_cnt
);

    localparam int unsigned       IDX_W     = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-3:0] REG_LIMIT = (ADDR_W - 2)'(NUM_REGS);

    if (WAIT_CYCLES > MAX_WAIT) begin : g_wait_check
        $error("bus_responder: WAIT_CYCLES must be in 0..19");
    end

    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0)
    begin : g_regs_check
        $error("bus_responder: NUM_REGS must be a power of two in 2..256");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;

    logic              s_ack_q, s_ack_d;
    logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
    logic              s_error_q, s_error_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [ADDR_W-1:0] txn_addr;
    logic [DATA_W-1:0] txn_wdata;
    logic              txn_wr;
    logic              txn_err;
    logic              enter_ack;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;

    // With WAIT_CYCLES=0 the ACK decision is taken on the capture edge, so look through
    // the capture registers while idle.
    always_comb begin
        txn_addr  = addr_q;
        txn_wdata = wdata_q;
        txn_wr    = wr_q;
        if (state_q == StIdle) begin
            txn_addr  = m_addr;
            txn_wdata = m_wdata;
            txn_wr    = m_wr_en;
        end
    end

    assign txn_err = (txn_addr[1:0] != 2'b00) || (txn_addr[ADDR_W-1:2] >= REG_LIMIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        unique case (state_q)
            StIdle: begin
                if (m_req) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wr_d    = m_wr_en;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? StAck : StWait;
                end
            end
            StWait: begin
                if (!m_req) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response, write commit and error count all resolve on the edge that enters ACK.
    always_comb begin
        enter_ack = (state_d == StAck) && (state_q != StAck);
        s_ack_d   = enter_ack;
        s_error_d = enter_ack && txn_err;
        s_rdata_d = (enter_ack && !txn_err && !txn_wr) ? rf_rdata : '0;
        rf_we     = enter_ack && txn_wr && !txn_err;
        err_cnt_d = err_cnt_q;
        if (enter_ack && txn_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            s_ack_q   <= 1'b0;
            s_rdata_q <= '0;
            s_error_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            s_ack_q   <= s_ack_d;
            s_rdata_q <= s_rdata_d;
            s_error_q <= s_error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    bus_resp_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .waddr (txn_addr[IDX_W+1:2]),
        .wdata (txn_wdata),
        .raddr (txn_addr[IDX_W+1:2]),
        .rdata (rf_rdata)
    );

    assign s_ack   = s_ack_q;
    assign s_rdata = s_rdata_q;
    assign s_error = s_error_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, giving the number of 32-bit registers (power of two, 2..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving extra response latency in cycles (legal 0..19).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port m_req  input  1  request from master; held until s_ack.
REQ-006 SHALL have port m_addr  input  32  byte address.
REQ-007 SHALL have port m_wdata  input  32  write data.
REQ-008 SHALL have port m_wr_en  input  1  1 = write, 0 = read.
REQ-009 SHALL have port s_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port s_rdata  output  32  read data, meaningful only while s_ack=1 and the request was a read.
REQ-011 SHALL have port s_error  output  1  error flag, meaningful only while s_ack=1.
REQ-012 SHALL have port err_cnt  output  8  saturating count of error responses.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT, ACK.
REQ-014 SHALL, in IDLE with m_req=1, capture m_addr/m_wdata/m_wr_en and load the wait counter with WAIT_CYCLES; next state WAIT, or ACK if WAIT_CYCLES=0.
REQ-015 SHALL, in WAIT, decrement the counter each cycle and go to ACK when the counter reaches 0.
REQ-016 SHALL drive s_ack=1 for exactly one cycle in ACK, then return to IDLE.
REQ-017 SHALL give latency from m_req sampled in IDLE at cycle T to s_ack=1 at cycle T+1+WAIT_CYCLES (1..20 cycles).
REQ-018 SHALL abort without ack or write, returning to IDLE, if m_req=0 is sampled in WAIT, so that s_ack never asserts without m_req.
REQ-019 SHALL treat m_req=1 in the cycle after ACK as a new transaction; back-to-back throughput SHALL be one transaction per 2+WAIT_CYCLES cycles.
REQ-020 SHALL flag an error when the captured addr[1:0] != 0 or addr>>2 >= NUM_REGS (the full upper bits are compared, with no aliasing).
REQ-021 SHALL, for an error response, drive s_error=1 and s_rdata=0, with no register written.
REQ-022 SHALL commit a non-error write at the ACK cycle edge, with s_rdata=0 and s_error=0.
REQ-023 SHALL, for a non-error read, return the register value current at entry to ACK, so that a read immediately after a write returns the new data.
REQ-024 SHALL hold s_ack, s_rdata and s_error at 0 outside ACK; all outputs SHALL be registered.
REQ-025 SHALL increment err_cnt by 1 per error response and saturate at 255 with no wrap.

Reset
REQ-026 SHALL, on rst_n=0 and regardless of clk, force state=IDLE, counter=0, s_ack=0, s_rdata=0, s_error=0, err_cnt=0, and all registers to 0.
REQ-027 SHALL, on reset mid-transaction (WAIT or ACK), drop the transaction with no ack after reset release and no write.
REQ-028 SHALL accept a new request on the first clk edge after rst_n rises.

Structure
REQ-029 SHALL place the state enum (IDLE/WAIT/ACK), ADDR_W=32 and DATA_W=32 in shared package bus_resp_pkg.
REQ-030 SHALL instantiate register storage as sub-module bus_resp_regfile (one write port, one read port, async clear); the FSM, counter and error logic SHALL stay in bus_responder.
REQ-031 SHALL flag WAIT_CYCLES > 19 at elaboration.

Verification
REQ-032 SHALL cover, with WAIT=2: write 0x8 data 0xDEADBEEF, then read 0x8 -> each s_ack exactly 3 cycles after req, read s_rdata=0xDEADBEEF, s_error=0.
REQ-033 SHALL cover a read of addr 0x6 (misaligned) and then a read of 0x40 with NUM_REGS=16 -> s_ack with s_error=1, s_rdata=0, err_cnt=2, no register changed.
REQ-034 SHALL cover, with WAIT=0 and m_req held high across 3 transactions -> s_ack pulses at T+1, T+3, T+5, never on consecutive cycles.
REQ-035 SHALL cover m_req dropped in the WAIT state -> no s_ack, target register unchanged, FSM back in IDLE.
REQ-036 SHALL cover rst_n pulsed low during WAIT of a write to 0x0 -> outputs 0 immediately, no ack, a read of 0x0 returns 0.
REQ-037 SHALL cover 260 error requests -> err_cnt saturates at 255; bind the master_slave_contract slave-side checks (ack within 1..20 cycles, no spurious ack, no X on rdata for reads) throughout.
